// File: rtl/note_tone_player_if.sv
// rtl/note_tone_player_if.sv - note request handshake bundle for note_tone_player
interface note_tone_player_if #(
  parameter int DUR_W = 8
);
  logic             note_valid;
  logic             note_ready;
  logic [2:0]       octave;
  logic [3:0]       note;
  logic [DUR_W-1:0] duration;

  modport master (
    output note_valid, octave, note, duration,
    input  note_ready
  );

  modport slave (
    input  note_valid, octave, note, duration,
    output note_ready
  );
endinterface

// File: rtl/note_tone_player.sv
// rtl/note_tone_player.sv - square-wave note player with duration timing
// Optional GAP articulation state enabled by macro NOTE_GAP_EN.
module note_tone_player #(
  parameter int DUR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  note_tone_player_if.slave   note_bus,
  input  logic                dur_tick,
  output logic                speaker,
  output logic                busy
);

`ifdef NOTE_GAP_EN
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

  state_t           state_q, state_d;
  logic [2:0]       oct_q, oct_d;
  logic [3:0]       note_q, note_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [7:0]       pre_q, pre_d;
  logic [8:0]       cnt_q, cnt_d;
  logic             spk_q, spk_d;

  // Table holds divider-1 so the 512 entry fits the 9-bit note counter.
  function automatic logic [8:0] div_m1(input logic [3:0] n);
    logic [8:0] d;
    case (n)
      4'd0:    d = 9'd511;
      4'd1:    d = 9'd482;
      4'd2:    d = 9'd455;
      4'd3:    d = 9'd430;
      4'd4:    d = 9'd405;
      4'd5:    d = 9'd383;
      4'd6:    d = 9'd361;
      4'd7:    d = 9'd341;
      4'd8:    d = 9'd322;
      4'd9:    d = 9'd303;
      4'd10:   d = 9'd286;
      4'd11:   d = 9'd270;
      default: d = 9'd0;
    endcase
    return d;
  endfunction

  always_comb begin
    state_d = state_q;
    oct_d   = oct_q;
    note_d  = note_q;
    dur_d   = dur_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    spk_d   = spk_q;
    unique case (state_q)
      IDLE: begin
        spk_d = 1'b0;
        if (note_bus.note_valid) begin
          oct_d  = note_bus.octave;
          note_d = note_bus.note;
          dur_d  = note_bus.duration;
          if (note_bus.duration != '0) begin
            state_d = PLAY;
            if (note_bus.note < 4'd12) begin
              pre_d = 8'hFF >> note_bus.octave;
              cnt_d = div_m1(note_bus.note);
            end else begin
              pre_d = 8'd0;
              cnt_d = 9'd0;
            end
          end
        end
      end
      PLAY: begin
        if (note_q < 4'd12) begin
          if (pre_q == 8'd0) begin
            pre_d = 8'hFF >> oct_q;
            if (cnt_q == 9'd0) begin
              cnt_d = div_m1(note_q);
              spk_d = ~spk_q;
            end else begin
              cnt_d = cnt_q - 9'd1;
            end
          end else begin
            pre_d = pre_q - 8'd1;
          end
        end
        if (dur_tick) begin
          dur_d = dur_q - DUR_W'(1);
          // Final tick wins over any toggle scheduled for the same edge.
          if (dur_q == DUR_W'(1)) begin
            spk_d = 1'b0;
            pre_d = 8'd0;
            cnt_d = 9'd0;
`ifdef NOTE_GAP_EN
            state_d = GAP;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef NOTE_GAP_EN
      GAP: begin
        spk_d = 1'b0;
        if (dur_tick) state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
        spk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      oct_q   <= 3'd0;
      note_q  <= 4'd0;
      dur_q   <= '0;
      pre_q   <= 8'd0;
      cnt_q   <= 9'd0;
      spk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      oct_q   <= oct_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      spk_q   <= spk_d;
    end
  end

  assign note_bus.note_ready = (state_q == IDLE);
  assign busy                = (state_q != IDLE);
  assign speaker             = spk_q;

endmodule

// File: tb/tb_note_tone_player.sv
// tb/tb_note_tone_player.sv - directed self-checking bench for note_tone_player
module tb_note_tone_player;
  logic clk = 1'b0;
  logic rst;
  logic dur_tick;
  logic speaker;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   n;
  logic seen;

  note_tone_player_if #(.DUR_W(8)) bus ();

  note_tone_player #(.DUR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .note_bus (bus.slave),
    .dur_tick (dur_tick),
    .speaker  (speaker),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] oct, input logic [3:0] nt, input logic [7:0] dur,
                      input logic tick);
    @(negedge clk);
    bus.note_valid = 1'b1;
    bus.octave     = oct;
    bus.note       = nt;
    bus.duration   = dur;
    dur_tick       = tick;
    @(posedge clk);
    #1;
    bus.note_valid = 1'b0;
    dur_tick       = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    dur_tick = 1'b1;
    @(negedge clk);
    dur_tick = 1'b0;
  endtask

  // Edges counted from the current point until speaker changes; bound expiry returns bound.
  task automatic measure(input int bound, output int cnt);
    logic start;
    start = speaker;
    cnt   = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (speaker === start && cnt < bound);
  endtask

  task automatic watch_quiet(input int cycles, output logic hit);
    hit = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (speaker !== 1'b0 || busy !== 1'b0) hit = 1'b1;
    end
  endtask

  initial begin
    rst            = 1'b1;
    dur_tick       = 1'b0;
    bus.note_valid = 1'b0;
    bus.octave     = 3'd0;
    bus.note       = 4'd0;
    bus.duration   = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_speaker", speaker, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.note_ready, 1);
    rst = 1'b0;

    pulse_tick();
    chk("idle_tick_busy", busy, 0);

    // octave 7, note 0: half-period 2*512 = 1024
    send(3'd7, 4'd0, 8'd3, 1'b0);
    chk("play_busy", busy, 1);
    chk("play_ready", bus.note_ready, 0);
    measure(2000, n);
    chk("o7_first_toggle", n, 1024);
    chk("o7_speaker_high", speaker, 1);
    bus.note_valid = 1'b1;
    bus.octave     = 3'd0;
    bus.note       = 4'd5;
    bus.duration   = 8'd200;
    measure(2000, n);
    bus.note_valid = 1'b0;
    chk("busy_ignore_valid_period", n, 1024);
    pulse_tick();
    pulse_tick();
    chk("o7_busy_after2", busy, 1);
    pulse_tick();
    chk("o7_speaker_end", speaker, 0);
`ifdef NOTE_GAP_EN
    chk("o7_gap_busy", busy, 1);
    pulse_tick();
`endif
    chk("o7_busy_end", busy, 0);
    chk("o7_ready_end", bus.note_ready, 1);

    // octave 5, note 9: half-period 8*304 = 2432
    send(3'd5, 4'd9, 8'd1, 1'b0);
    measure(4000, n);
    chk("o5n9_first_toggle", n, 2432);
    pulse_tick();
`ifdef NOTE_GAP_EN
    chk("gap_busy", busy, 1);
    chk("gap_speaker", speaker, 0);
    pulse_tick();
`endif
    chk("dur1_busy_end", busy, 0);

    // rest note with a tick in the transfer cycle that must not count
    send(3'd3, 4'd12, 8'd2, 1'b1);
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (speaker !== 1'b0) seen = 1'b1;
    end
    chk("rest_busy", busy, 1);
    pulse_tick();
    chk("rest_busy_tick1", busy, 1);
    chk("rest_speaker_quiet", seen, 0);
    pulse_tick();
`ifdef NOTE_GAP_EN
    pulse_tick();
`endif
    chk("rest_busy_end", busy, 0);
    chk("rest_ready_end", bus.note_ready, 1);

    // zero-duration transfer does nothing
    send(3'd7, 4'd0, 8'd0, 1'b0);
    chk("dur0_ready", bus.note_ready, 1);
    watch_quiet(100, seen);
    chk("dur0_quiet", seen, 0);

    // reset mid-note while speaker is high, with a competing request
    send(3'd7, 4'd0, 8'd5, 1'b0);
    measure(2000, n);
    chk("rst_pre_speaker", speaker, 1);
    @(negedge clk);
    rst            = 1'b1;
    bus.note_valid = 1'b1;
    bus.octave     = 3'd7;
    bus.note       = 4'd0;
    bus.duration   = 8'd4;
    @(negedge clk);
    chk("midrst_speaker", speaker, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", bus.note_ready, 1);
    rst            = 1'b0;
    bus.note_valid = 1'b0;
    watch_quiet(50, seen);
    chk("midrst_no_accept", seen, 0);

    // octave 0, note 11: half-period 256*271 = 69376
    send(3'd0, 4'd11, 8'd1, 1'b0);
    measure(80000, n);
    chk("o0n11_half_period", n, 69376);
    pulse_tick();
`ifdef NOTE_GAP_EN
    pulse_tick();
`endif
    chk("o0_speaker_end", speaker, 0);
    chk("o0_busy_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_tone_player.md
NOTE_TONE_PLAYER -- requirements
Module: note_tone_player

Interface
REQ-001 SHALL have parameter DUR_W, default 8: width of the note duration field, in dur_tick units.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port note_valid  input  1  request to play the presented note.
REQ-005 SHALL have port note_ready  output  1  player can accept a note; transfer occurs on note_valid && note_ready.
REQ-006 SHALL have port octave  input  3  octave from the upstream divide-by-12 stage; 0 = lowest, 7 = highest.
REQ-007 SHALL have port note  input  4  note within the octave from the divide-by-12 stage; 0..11 = tone, 12..15 = rest.
REQ-008 SHALL have port duration  input  DUR_W  note length in dur_tick strobes.
REQ-009 SHALL have port dur_tick  input  1  single-cycle timebase strobe (e.g. 1 ms).
REQ-010 SHALL have port speaker  output  1  square-wave tone output.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, PLAY and GAP, with note_ready = (state == IDLE).
REQ-013 SHALL, on a transfer, latch octave, note and duration, and enter PLAY on the next edge.
  - Exception: if duration == 0, SHALL stay in IDLE and never toggle speaker.
REQ-014 SHALL use this 9-bit divider table, indexed by note 0..11: 512, 483, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271.
REQ-015 SHALL run an 8-bit prescaler, reloaded at transfer and on reaching 0 with (8'hFF >> octave), decrementing every clock in PLAY.
REQ-016 SHALL run a 9-bit note counter, reloaded at transfer and on wrap with divider-1, decrementing only on cycles where the prescaler == 0.
REQ-017 SHALL toggle speaker on cycles where both counters == 0; half-period = (256 >> octave) * divider clocks.
  - First toggle occurs exactly one half-period after the transfer edge.
REQ-018 SHALL hold speaker at 0 and the counters idle for a rest note (note >= 12), while still timing the duration.
REQ-019 SHALL decrement a duration counter on each dur_tick in PLAY.
  - A dur_tick in the transfer cycle is not counted.
REQ-020 SHALL leave PLAY on the dur_tick that brings the duration count to 0.
  - speaker is forced to 0 on that same edge.
REQ-021 SHALL ignore note_valid while busy; no queuing, and latched values are unchanged.
REQ-022 SHALL ignore dur_tick in IDLE.
REQ-023 SHALL keep speaker at 0 in IDLE and GAP.

Reset
REQ-024 SHALL, on rst, set state = IDLE, speaker = 0, busy = 0, note_ready = 1, and zero all counters and latched fields.
REQ-025 SHALL give rst priority over every other event, including a mid-note reset and a transfer in the same cycle.
  - No toggle occurs on the reset edge.

Configuration
REQ-026 SHALL support macro NOTE_GAP_EN.
  - When defined: PLAY exits to GAP, and GAP returns to IDLE on the next dur_tick (one tick of articulation silence).
  - When undefined: the GAP state does not exist, and PLAY exits directly to IDLE.

Verification
REQ-027 SHALL test: octave=7, note=0, duration=3 -> first speaker toggle 1024 clocks after transfer; busy for exactly 3 dur_ticks; speaker 0 after.
REQ-028 SHALL test: octave=0, note=11 -> speaker half-period measured at 69376 clocks.
REQ-029 SHALL test: note=12, duration=2 -> speaker constant 0; busy high until the 2nd dur_tick; note_ready returns to 1.
REQ-030 SHALL test: duration=0 transfer -> note_ready stays 1; speaker never toggles; busy never rises.
REQ-031 SHALL test: rst asserted mid-PLAY while speaker=1 -> next edge gives speaker=0, state IDLE, note_ready=1; a note_valid held during rst is not accepted.
REQ-032 SHALL test: with NOTE_GAP_EN, duration=1 -> busy spans 2 dur_ticks and speaker is 0 during GAP; without the macro, busy spans 1 dur_tick.
